// File: rtl/modinv_fermat.sv
// Fermat modular inverter for q = 3329: out_r = in_a^(q-2) mod q via square-and-multiply
// on one pipelined modular multiplier. Define MODINV_SELFCHECK_EN to add a final r*a == 1 check.

module modinv_mul #(
  parameter int PIPE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld_i,
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic        vld_o,
  output logic [11:0] r_o
);
  localparam logic [11:0] Q  = 12'd3329;
  localparam logic [35:0] BM = 36'd5039;  // floor(2^24 / Q)

  // Barrett reduction of a < Q^2 product; the estimate is at most two Q short.
  function automatic logic [11:0] reduce(input logic [23:0] p);
    logic [11:0] qt;
    logic [13:0] r;
    qt = 12'((36'(p) * BM) >> 24);
    r  = 14'(p - 24'(qt) * 24'(Q));
    if (r >= 14'(Q)) r = r - 14'(Q);
    if (r >= 14'(Q)) r = r - 14'(Q);
    return 12'(r);
  endfunction

  logic [PIPE:1] vld_pipe;
  logic [23:0]   prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      prod_q   <= '0;
    end else begin
      vld_pipe[1] <= vld_i;
      for (int i = 2; i <= PIPE; i++) vld_pipe[i] <= vld_pipe[i-1];
      prod_q <= 24'(a_i) * 24'(b_i);
    end
  end

  assign vld_o = vld_pipe[PIPE];

  generate
    if (PIPE == 1) begin : g_p1
      assign r_o = reduce(prod_q);
    end else begin : g_pn
      logic [PIPE-2:0][11:0] res_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else begin
          res_q[0] <= reduce(prod_q);
          for (int i = 1; i <= PIPE - 2; i++) res_q[i] <= res_q[i-1];
        end
      end
      assign r_o = res_q[PIPE-2];
    end
  endgenerate
endmodule

module modinv_fermat #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_r,
  output logic        out_err,
  output logic        chk_fail
);
  localparam logic [11:0] Q = 12'd3329;
  localparam logic [11:0] E = 12'b1100_1111_1111;

`ifdef MODINV_SELFCHECK_EN
  typedef enum logic [2:0] {IDLE, SQR, MUL, CHK, DONE} state_t;
  localparam state_t LAST_ST = CHK;
`else
  typedef enum logic [2:0] {IDLE, SQR, MUL, DONE} state_t;
  localparam state_t LAST_ST = DONE;
`endif

  state_t      state_q;
  logic [11:0] a_q, acc_q, out_r_q;
  logic [3:0]  k_q;
  logic        wait_q, in_ready_q, out_valid_q, out_err_q;
  logic        mul_go, mul_vld;
  logic [11:0] mul_b, mul_r;

  // Operands come straight from registers that only change at op end, so they hold for the whole op.
  assign mul_go = (state_q == SQR || state_q == MUL
`ifdef MODINV_SELFCHECK_EN
                   || state_q == CHK
`endif
                  ) && !wait_q;
  assign mul_b  = (state_q == SQR) ? acc_q : a_q;

  modinv_mul #(.PIPE(MUL_LAT)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (mul_go),
    .a_i   (acc_q),
    .b_i   (mul_b),
    .vld_o (mul_vld),
    .r_o   (mul_r)
  );

`ifdef MODINV_SELFCHECK_EN
  logic chk_fail_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        chk_fail_q <= 1'b0;
    else if (state_q == IDLE && in_valid && in_ready_q) chk_fail_q <= 1'b0;
    else if (state_q == CHK && !mul_go && mul_vld)      chk_fail_q <= (mul_r != 12'd1);
  end
  assign chk_fail = chk_fail_q;
`else
  assign chk_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      wait_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          in_ready_q <= 1'b0;
          wait_q     <= 1'b0;
          a_q        <= in_a;
          k_q        <= 4'd10;
          if (in_a == 12'd0 || in_a >= Q) begin
            acc_q     <= '0;
            out_err_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            acc_q     <= in_a;
            out_err_q <= 1'b0;
            state_q   <= SQR;
          end
        end
        SQR: begin
          if (mul_go) wait_q <= 1'b1;
          else if (mul_vld) begin
            wait_q <= 1'b0;
            acc_q  <= mul_r;
            if (E[k_q])             state_q <= MUL;
            else if (k_q == 4'd0)   state_q <= LAST_ST;
            else                    k_q     <= k_q - 4'd1;
          end
        end
        MUL: begin
          if (mul_go) wait_q <= 1'b1;
          else if (mul_vld) begin
            wait_q <= 1'b0;
            acc_q  <= mul_r;
            if (k_q == 4'd0) state_q <= LAST_ST;
            else begin
              k_q     <= k_q - 4'd1;
              state_q <= SQR;
            end
          end
        end
`ifdef MODINV_SELFCHECK_EN
        CHK: begin
          if (mul_go) wait_q <= 1'b1;
          else if (mul_vld) begin
            wait_q  <= 1'b0;
            state_q <= DONE;
          end
        end
`endif
        DONE: begin
          // First DONE cycle publishes the result; afterwards wait for the consumer.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_r_q     <= acc_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_err   = out_err_q;
endmodule
